fft16_seq_ctrl: RTL and testbench

- Sequencer for the 16-point radix-4 FFT datapath. It drives the input ROM address, the deserializer write strobes and the two butterfly-stage enables, then presents an output-valid/ready handshake.
- One frame is 32 ROM words: 16 real words, then 16 imaginary words.
- The block sits beside the FFT top level and replaces the free-running external address input with a start/done controlled frame fetch.

---
 rtl/fft_pkg.sv | 18 +
 rtl/fft16_seq_ctrl_if.sv | 37 +++
 rtl/fft_seq_dly.sv | 43 ++++
 rtl/fft16_seq_ctrl.sv | 145 ++++++++++++++
 tb/tb_fft16_seq_ctrl.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/fft_pkg.sv
// Shared definitions for the 16-point FFT sequencer.
// Holds the sequencer state encoding and the frame geometry constants.
package fft_pkg;

  localparam int unsigned FFT_N     = 16;
  localparam int unsigned FFT_WORDS = 32;
  localparam int unsigned DES_IDX_W = 5;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDrain,
    StBf1,
    StBf2,
    StOutv
  } seq_state_e;

endpackage

// File: rtl/fft16_seq_ctrl_if.sv
// Control/handshake bundle between the FFT sequencer and its environment.
//   start, abort, frame_base : frame request side (driven by the environment)
//   rom_addr                 : ROM read address
//   des_we, des_idx          : deserializer write strobe and slot
//   bf1_en, bf2_en           : butterfly stage register enables
//   out_valid, out_ready     : result handshake
//   busy, done               : status; done pulses when the result is accepted
// Modports: master = sequencer, slave = environment.
interface fft16_seq_ctrl_if #(
  parameter int unsigned ADDR_W = 6
);
  import fft_pkg::*;

  logic                 start;
  logic                 abort;
  logic [ADDR_W-1:0]    frame_base;
  logic [ADDR_W-1:0]    rom_addr;
  logic                 des_we;
  logic [DES_IDX_W-1:0] des_idx;
  logic                 bf1_en;
  logic                 bf2_en;
  logic                 out_valid;
  logic                 out_ready;
  logic                 busy;
  logic                 done;

  modport master (
    input  start, abort, frame_base, out_ready,
    output rom_addr, des_we, des_idx, bf1_en, bf2_en, out_valid, busy, done
  );

  modport slave (
    output start, abort, frame_base, out_ready,
    input  rom_addr, des_we, des_idx, bf1_en, bf2_en, out_valid, busy, done
  );

endinterface

// File: rtl/fft_seq_dly.sv
// Depth-stage delay line for a valid flag plus index, with synchronous flush.
// Aligns the deserializer write strobe/slot with ROM read data.
//   clk, reset        : clock, asynchronous active-low reset
//   flush             : clears every stage at the next edge
//   in_vld, in_idx    : undelayed valid/index
//   out_vld, out_idx  : values delayed by Depth cycles
module fft_seq_dly #(
  parameter int unsigned Depth = 1,
  parameter int unsigned Width = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_vld,
  input  logic [Width-1:0] in_idx,
  output logic             out_vld,
  output logic [Width-1:0] out_idx
);

  logic [Depth-1:0] vld_q;
  logic [Width-1:0] idx_q [Depth];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_q <= '0;
      for (int i = 0; i < Depth; i++) idx_q[i] <= '0;
    end else if (flush) begin
      vld_q <= '0;
      for (int i = 0; i < Depth; i++) idx_q[i] <= '0;
    end else begin
      vld_q[0] <= in_vld;
      idx_q[0] <= in_idx;
      for (int i = 1; i < Depth; i++) begin
        vld_q[i] <= vld_q[i-1];
        idx_q[i] <= idx_q[i-1];
      end
    end
  end

  assign out_vld = vld_q[Depth-1];
  assign out_idx = idx_q[Depth-1];

endmodule

// File: rtl/fft16_seq_ctrl.sv
// Frame sequencer for the 16-point radix-4 FFT datapath.
// Fetches N_WORDS ROM words from a captured base, drives the deserializer
// strobes through a ROM_LAT delay line, pulses the two butterfly enables,
// then holds out_valid until out_ready.
//   clk, reset : clock, asynchronous active-low reset
//   bus        : fft16_seq_ctrl_if master modport (see interface header)
// Optional macro FFT_SEQ_CONT_EN: after each accepted result, fetch the next
// frame at base + N_WORDS immediately instead of returning to IDLE.
module fft16_seq_ctrl
  import fft_pkg::*;
#(
  parameter int unsigned ADDR_W  = 6,
  parameter int unsigned N_WORDS = FFT_WORDS,
  parameter int unsigned ROM_LAT = 1,
  parameter int unsigned BF1_LAT = 1,
  parameter int unsigned BF2_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  fft16_seq_ctrl_if.master  bus
);

  localparam int unsigned CNT_W = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam int unsigned TMR_W = 16;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_WORDS - 1);

  seq_state_e        state_q;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] rom_addr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [TMR_W-1:0]  tmr_q;
  logic              bf1_en_q;
  logic              bf2_en_q;
  logic              out_valid_q;

`ifdef FFT_SEQ_CONT_EN
  logic [ADDR_W-1:0] next_base;
  assign next_base = base_q + ADDR_W'(N_WORDS);
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      base_q      <= '0;
      rom_addr_q  <= '0;
      cnt_q       <= '0;
      tmr_q       <= '0;
      bf1_en_q    <= 1'b0;
      bf2_en_q    <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (bus.abort) begin
      // Abort wins over start, out_ready and every timer; rom_addr holds.
      state_q     <= StIdle;
      cnt_q       <= '0;
      tmr_q       <= '0;
      bf1_en_q    <= 1'b0;
      bf2_en_q    <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            state_q    <= StFetch;
            base_q     <= bus.frame_base;
            rom_addr_q <= bus.frame_base;
            cnt_q      <= '0;
          end
        end
        StFetch: begin
          if (cnt_q == LAST_CNT) begin
            state_q <= StDrain;
            tmr_q   <= TMR_W'(ROM_LAT - 1);
          end else begin
            cnt_q      <= cnt_q + CNT_W'(1);
            rom_addr_q <= base_q + ADDR_W'(cnt_q) + ADDR_W'(1);
          end
        end
        StDrain: begin
          if (tmr_q == '0) begin
            state_q  <= StBf1;
            bf1_en_q <= 1'b1;
            tmr_q    <= TMR_W'(BF1_LAT - 1);
          end else begin
            tmr_q <= tmr_q - TMR_W'(1);
          end
        end
        StBf1: begin
          if (tmr_q == '0) begin
            state_q  <= StBf2;
            bf1_en_q <= 1'b0;
            bf2_en_q <= 1'b1;
            tmr_q    <= TMR_W'(BF2_LAT - 1);
          end else begin
            tmr_q <= tmr_q - TMR_W'(1);
          end
        end
        StBf2: begin
          if (tmr_q == '0) begin
            state_q     <= StOutv;
            bf2_en_q    <= 1'b0;
            out_valid_q <= 1'b1;
          end else begin
            tmr_q <= tmr_q - TMR_W'(1);
          end
        end
        StOutv: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
`ifdef FFT_SEQ_CONT_EN
            state_q    <= StFetch;
            base_q     <= next_base;
            rom_addr_q <= next_base;
            cnt_q      <= '0;
`else
            state_q <= StIdle;
`endif
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  fft_seq_dly #(
    .Depth (ROM_LAT),
    .Width (DES_IDX_W)
  ) u_dly (
    .clk     (clk),
    .reset   (reset),
    .flush   (bus.abort),
    .in_vld  (state_q == StFetch),
    .in_idx  (DES_IDX_W'(cnt_q)),
    .out_vld (bus.des_we),
    .out_idx (bus.des_idx)
  );

  assign bus.rom_addr  = rom_addr_q;
  assign bus.bf1_en    = bf1_en_q;
  assign bus.bf2_en    = bf2_en_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = (state_q != StIdle);
  // done must appear in the accepting cycle itself, so it is decoded from the handshake.
  assign bus.done      = out_valid_q & bus.out_ready & ~bus.abort;

endmodule

// File: tb/tb_fft16_seq_ctrl.sv
// Self-checking bench for fft16_seq_ctrl (default build, macro undefined).
module tb_fft16_seq_ctrl;
  import fft_pkg::*;

  localparam int unsigned ADDR_W  = 6;
  localparam int unsigned N_WORDS = 32;
  localparam int unsigned ROM_LAT = 1;
  localparam int unsigned BF1_LAT = 1;
  localparam int unsigned BF2_LAT = 1;
  localparam int T0 = 1 + N_WORDS + ROM_LAT + BF1_LAT + BF2_LAT;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  fft16_seq_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  fft16_seq_ctrl #(
    .ADDR_W  (ADDR_W),
    .N_WORDS (N_WORDS),
    .ROM_LAT (ROM_LAT),
    .BF1_LAT (BF1_LAT),
    .BF2_LAT (BF2_LAT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: frame position t counts cycles since the accepting edge.
  bit m_act  = 1'b0;
  int m_t    = 0;
  int m_base = 0;
  int m_last = 0;

  int cnt_we, cnt_done, cnt_busy;

  typedef struct {
    int base;
    int wait_c;
    int abort_t;
    int start_a;
    int start_b;
    int exp_we;
    int exp_done;
    int exp_busy;
  } scen_t;

  scen_t tbl [7];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s time=%0t actual=%0d required=%0d", name, $time, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rom_addr"}, int'(bus.rom_addr), 0);
    chk({tag, "_des_we"}, int'(bus.des_we), 0);
    chk({tag, "_des_idx"}, int'(bus.des_idx), 0);
    chk({tag, "_bf1_en"}, int'(bus.bf1_en), 0);
    chk({tag, "_bf2_en"}, int'(bus.bf2_en), 0);
    chk({tag, "_out_valid"}, int'(bus.out_valid), 0);
    chk({tag, "_busy"}, int'(bus.busy), 0);
    chk({tag, "_done"}, int'(bus.done), 0);
  endtask

  task automatic check_cycle();
    int  ea, eidx;
    bit  ewe, eb1, eb2, eov, edone;
    ea = m_last;
    if (m_act && m_t >= 1 && m_t <= N_WORDS) ea = (m_base + m_t - 1) % (1 << ADDR_W);
    m_last = ea;
    ewe   = m_act && m_t >= 1 + ROM_LAT && m_t <= N_WORDS + ROM_LAT;
    eidx  = m_t - 1 - ROM_LAT;
    eb1   = m_act && m_t > N_WORDS + ROM_LAT && m_t <= N_WORDS + ROM_LAT + BF1_LAT;
    eb2   = m_act && m_t > N_WORDS + ROM_LAT + BF1_LAT && m_t < T0;
    eov   = m_act && m_t >= T0;
    edone = eov && bus.out_ready && !bus.abort;
    chk("rom_addr", int'(bus.rom_addr), ea);
    chk("des_we", int'(bus.des_we), int'(ewe));
    if (ewe) chk("des_idx", int'(bus.des_idx), eidx);
    chk("bf1_en", int'(bus.bf1_en), int'(eb1));
    chk("bf2_en", int'(bus.bf2_en), int'(eb2));
    chk("out_valid", int'(bus.out_valid), int'(eov));
    chk("busy", int'(bus.busy), int'(m_act));
    chk("done", int'(bus.done), int'(edone));
  endtask

  task automatic model_edge();
    if (m_act && bus.abort) begin
      m_act = 1'b0;
    end else if (m_act) begin
      if (m_t >= T0 && bus.out_ready) m_act = 1'b0;
      else m_t++;
    end else if (bus.start && !bus.abort) begin
      m_act  = 1'b1;
      m_t    = 1;
      m_base = int'(bus.frame_base);
    end
  endtask

  // Check the current cycle at the falling edge, advance the model, then
  // return just after the next rising edge so the caller can drive inputs.
  task automatic tick();
    @(negedge clk);
    check_cycle();
    if (bus.des_we) cnt_we++;
    if (bus.done) cnt_done++;
    if (bus.busy) cnt_busy++;
    model_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time=%0t actual=running required=finished", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    //           base wait abort st_a st_b   we done busy
    tbl[0] = '{ 0,   4,   -1,   -1,  -1,    32, 1,   40  };  // basic frame
    tbl[1] = '{ 40,  0,   -1,   -1,  -1,    32, 1,   36  };  // address wrap
    tbl[2] = '{ 17,  100, -1,   -1,  -1,    32, 1,   136 };  // backpressure
    tbl[3] = '{ 5,   2,   -1,   10,  20,    32, 1,   38  };  // start while busy
    tbl[4] = '{ 63,  0,   16,   -1,  -1,    15, 0,   16  };  // abort at cnt=15
    tbl[5] = '{ 9,   3,   -1,   -1,  T0+3,  32, 1,   39  };  // start with out_ready
    tbl[6] = '{ 30,  1,   T0+1, -1,  -1,    32, 0,   37  };  // abort beats handshake

    bus.start      = 1'b0;
    bus.abort      = 1'b0;
    bus.frame_base = '0;
    bus.out_ready  = 1'b0;

    #7;
    chk_all_zero("reset");
    #5 reset = 1'b1;
    @(posedge clk);
    #1;

    for (int r = 0; r < 7; r++) begin
      cnt_we = 0; cnt_done = 0; cnt_busy = 0;
      bus.frame_base = ADDR_W'(tbl[r].base);
      bus.start      = 1'b1;
      bus.abort      = 1'b0;
      bus.out_ready  = 1'b0;
      tick();
      bus.start = 1'b0;
      guard = 0;
      while (m_act && guard < 400) begin
        bus.frame_base = ADDR_W'($urandom);
        bus.start      = (m_t == tbl[r].start_a) || (m_t == tbl[r].start_b);
        bus.abort      = (m_t == tbl[r].abort_t);
        if (m_t < T0) bus.out_ready = 1'($urandom_range(0, 1));
        else bus.out_ready = (m_t >= T0 + tbl[r].wait_c);
        tick();
        guard++;
      end
      chk("frame_timeout", int'(guard >= 400), 0);
      bus.start = 1'b0; bus.abort = 1'b0; bus.out_ready = 1'b0;
      tick();
      chk("we_count", cnt_we, tbl[r].exp_we);
      chk("done_count", cnt_done, tbl[r].exp_done);
      chk("busy_cycles", cnt_busy, tbl[r].exp_busy);
    end

    // Randomized traffic against the model; abort only while a frame is live.
    for (int i = 0; i < 600; i++) begin
      bus.frame_base = ADDR_W'($urandom);
      bus.start      = ($urandom_range(0, 3) == 0);
      bus.abort      = m_act && ($urandom_range(0, 60) == 0);
      bus.out_ready  = 1'($urandom_range(0, 1));
      tick();
    end

    bus.start = 1'b0;
    bus.out_ready = 1'b0;
    bus.abort = m_act;
    tick();
    bus.abort = 1'b0;

    // Asynchronous reset in the middle of BF1.
    bus.frame_base = 6'd11;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    guard = 0;
    while (!(m_act && m_t == N_WORDS + ROM_LAT + 1) && guard < 100) begin
      tick();
      guard++;
    end
    chk("bf1_wait_timeout", int'(guard >= 100), 0);
    chk("bf1_before_rst", int'(bus.bf1_en), 1);
    #2 reset = 1'b0;
    #1 chk_all_zero("async_rst");
    #2 reset = 1'b1;
    m_act  = 1'b0;
    m_last = 0;
    for (int i = 0; i < 3; i++) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
